// File: rtl/game_flow_controller_if.sv
// Game-flow signal bundle between the Frogger sequencer and the rest of the game.
// The master drives start/collision/level-up/pause; the slave returns flow status.
interface game_flow_controller_if #(
    parameter int C_LIVES = 3
);
    logic               i_Start;
    logic               i_Has_Collided;
    logic               i_Level_Up;
    logic               i_Pause;
    logic               o_Game_Active;
    logic               o_Freeze;
    logic               o_Frog_Respawn;
    logic [C_LIVES-1:0] o_Lives;
    logic [3:0]         o_Level;
    logic               o_Game_Over;

    modport master (
        output i_Start, i_Has_Collided, i_Level_Up, i_Pause,
        input  o_Game_Active, o_Freeze, o_Frog_Respawn, o_Lives, o_Level, o_Game_Over
    );

    modport slave (
        input  i_Start, i_Has_Collided, i_Level_Up, i_Pause,
        output o_Game_Active, o_Freeze, o_Frog_Respawn, o_Lives, o_Level, o_Game_Over
    );
endinterface

// File: rtl/game_flow_controller.sv
// Frogger game sequencer: lives, level, timed freeze phases and frog respawn.
// Define GAME_PAUSE_EN to add a PAUSED state toggled by rising edges of i_Pause.
module game_flow_controller #(
    parameter int C_LIVES          = 3,
    parameter int C_FREEZE_TICKS   = 12_500_000,
    parameter int C_GAMEOVER_TICKS = 50_000_000,
    parameter int C_LEVEL_MAX      = 15
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    game_flow_controller_if.slave         io_Bus
);

    localparam int C_TMAX = (C_FREEZE_TICKS > C_GAMEOVER_TICKS) ? C_FREEZE_TICKS : C_GAMEOVER_TICKS;
    localparam int C_TW   = $clog2(C_TMAX + 1);

`ifdef GAME_PAUSE_EN
    localparam int C_SW = 6;
`else
    localparam int C_SW = 5;
`endif

    localparam logic [C_SW-1:0] S_IDLE  = C_SW'(1);
    localparam logic [C_SW-1:0] S_RUN   = C_SW'(2);
    localparam logic [C_SW-1:0] S_HIT   = C_SW'(4);
    localparam logic [C_SW-1:0] S_LVL   = C_SW'(8);
    localparam logic [C_SW-1:0] S_OVER  = C_SW'(16);
`ifdef GAME_PAUSE_EN
    localparam logic [C_SW-1:0] S_PAUSE = C_SW'(32);
`endif

    logic [C_SW-1:0]    r_state;
    logic [C_SW-1:0]    w_state_next;
    logic [C_TW-1:0]    r_timer;
    logic [C_TW-1:0]    w_timer_next;
    logic [C_LIVES-1:0] r_lives;
    logic [C_LIVES-1:0] w_lives_next;
    logic [3:0]         r_level;
    logic [3:0]         w_level_next;
    logic               r_coll_d;
    logic               r_start_d;
    logic               r_game_active;
    logic               r_freeze;
    logic               r_respawn;
    logic               r_game_over;
    logic               w_active_next;
    logic               w_freeze_next;
    logic               w_respawn_next;
    logic               w_over_next;
    logic               w_coll_edge;
    logic               w_start_edge;
    logic               w_freeze_done;
    logic               w_over_done;
    logic               w_pause_edge;

    assign w_coll_edge   = io_Bus.i_Has_Collided & ~r_coll_d;
    assign w_start_edge  = io_Bus.i_Start & ~r_start_d;
    assign w_freeze_done = (r_timer == C_TW'(C_FREEZE_TICKS - 1));
    assign w_over_done   = (r_timer == C_TW'(C_GAMEOVER_TICKS - 1));

`ifdef GAME_PAUSE_EN
    logic r_pause_d;
    assign w_pause_edge = io_Bus.i_Pause & ~r_pause_d;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_pause_d <= 1'b0;
        else          r_pause_d <= io_Bus.i_Pause;
    end
`else
    logic w_unused_pause;
    assign w_unused_pause = io_Bus.i_Pause;
    assign w_pause_edge   = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Collision outranks level-up, which outranks pause; any unknown code falls back to IDLE.
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = w_start_edge ? S_RUN : S_IDLE;
            S_RUN: begin
                if (w_coll_edge)
                    w_state_next = (r_lives == C_LIVES'(1)) ? S_OVER : S_HIT;
                else if (io_Bus.i_Level_Up)
                    w_state_next = S_LVL;
`ifdef GAME_PAUSE_EN
                else if (w_pause_edge)
                    w_state_next = S_PAUSE;
`endif
                else
                    w_state_next = S_RUN;
            end
            S_HIT, S_LVL: w_state_next = w_freeze_done ? S_RUN : r_state;
            S_OVER:  w_state_next = w_over_done ? S_IDLE : S_OVER;
`ifdef GAME_PAUSE_EN
            S_PAUSE: w_state_next = w_pause_edge ? S_RUN : S_PAUSE;
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_lives_next   = r_lives;
        w_level_next   = r_level;
        w_respawn_next = 1'b0;
        if (r_state == S_IDLE && w_state_next == S_RUN) begin
            w_lives_next   = '1;
            w_level_next   = 4'd0;
            w_respawn_next = 1'b1;
        end
        if (r_state == S_RUN && w_state_next == S_OVER)
            w_lives_next = '0;
        if (r_state == S_RUN && w_state_next == S_HIT)
            w_lives_next = r_lives >> 1;
        if (r_state == S_RUN && w_state_next == S_LVL)
            w_level_next = (r_level >= 4'(C_LEVEL_MAX)) ? 4'(C_LEVEL_MAX) : r_level + 4'd1;
        if ((r_state == S_HIT || r_state == S_LVL) && w_state_next == S_RUN)
            w_respawn_next = 1'b1;

        if (w_state_next != r_state)
            w_timer_next = '0;
        else if (r_state == S_HIT || r_state == S_LVL || r_state == S_OVER)
            w_timer_next = r_timer + C_TW'(1);
        else
            w_timer_next = '0;

        w_active_next = (w_state_next == S_RUN);
        w_over_next   = (w_state_next == S_OVER);
        w_freeze_next = (w_state_next == S_HIT) || (w_state_next == S_LVL) || (w_state_next == S_OVER);
`ifdef GAME_PAUSE_EN
        if (w_state_next == S_PAUSE)
            w_freeze_next = 1'b1;
`endif
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_timer       <= '0;
            r_lives       <= '1;
            r_level       <= 4'd0;
            r_coll_d      <= 1'b0;
            r_start_d     <= 1'b0;
            r_game_active <= 1'b0;
            r_freeze      <= 1'b0;
            r_respawn     <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_timer       <= w_timer_next;
            r_lives       <= w_lives_next;
            r_level       <= w_level_next;
            r_coll_d      <= io_Bus.i_Has_Collided;
            r_start_d     <= io_Bus.i_Start;
            r_game_active <= w_active_next;
            r_freeze      <= w_freeze_next;
            r_respawn     <= w_respawn_next;
            r_game_over   <= w_over_next;
        end
    end

    assign io_Bus.o_Game_Active  = r_game_active;
    assign io_Bus.o_Freeze       = r_freeze;
    assign io_Bus.o_Frog_Respawn = r_respawn;
    assign io_Bus.o_Lives        = r_lives;
    assign io_Bus.o_Level        = r_level;
    assign io_Bus.o_Game_Over    = r_game_over;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with short freeze/game-over timers.
module tb_game_flow_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   nf;
    int   nr;
    int   no;

    always #5 clk = ~clk;

    game_flow_controller_if #(.C_LIVES(3)) bus ();

    game_flow_controller #(
        .C_LIVES(3),
        .C_FREEZE_TICKS(4),
        .C_GAMEOVER_TICKS(8),
        .C_LEVEL_MAX(15)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_n),
        .io_Bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.i_Start        = 1'b0;
        bus.i_Has_Collided = 1'b0;
        bus.i_Level_Up     = 1'b0;
        bus.i_Pause        = 1'b0;
        repeat (3) tick();
        $display("step reset");
        chk("rst_lives",   int'(bus.o_Lives), 7);
        chk("rst_level",   int'(bus.o_Level), 0);
        chk("rst_active",  int'(bus.o_Game_Active), 0);
        chk("rst_freeze",  int'(bus.o_Freeze), 0);
        chk("rst_respawn", int'(bus.o_Frog_Respawn), 0);
        chk("rst_over",    int'(bus.o_Game_Over), 0);
        rst_n = 1'b1;
        tick();

        $display("step start game");
        bus.i_Start = 1'b1;
        tick();
        chk("t1_active",  int'(bus.o_Game_Active), 1);
        chk("t1_respawn", int'(bus.o_Frog_Respawn), 1);
        chk("t1_lives",   int'(bus.o_Lives), 7);
        chk("t1_level",   int'(bus.o_Level), 0);
        tick();
        chk("t1_respawn_pulse", int'(bus.o_Frog_Respawn), 0);
        chk("t1_active_hold",   int'(bus.o_Game_Active), 1);

        $display("step collision held 20 cycles");
        bus.i_Has_Collided = 1'b1;
        nf = 0;
        nr = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) chk("t2_lives_hit", int'(bus.o_Lives), 3);
            nf += int'(bus.o_Freeze);
            nr += int'(bus.o_Frog_Respawn);
        end
        chk("t2_freeze_cycles",  nf, 4);
        chk("t2_respawn_pulses", nr, 1);
        chk("t2_lives_final",    int'(bus.o_Lives), 3);
        chk("t2_active",         int'(bus.o_Game_Active), 1);
        bus.i_Has_Collided = 1'b0;
        tick();

        $display("step second collision");
        bus.i_Has_Collided = 1'b1;
        tick();
        chk("t3_lives_1", int'(bus.o_Lives), 1);
        bus.i_Has_Collided = 1'b0;
        repeat (4) tick();
        chk("t3_back_run", int'(bus.o_Game_Active), 1);

        $display("step last collision");
        bus.i_Has_Collided = 1'b1;
        tick();
        chk("t3_lives_0",    int'(bus.o_Lives), 0);
        chk("t3_over",       int'(bus.o_Game_Over), 1);
        chk("t3_over_freez", int'(bus.o_Freeze), 1);
        bus.i_Has_Collided = 1'b0;
        no = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            no += int'(bus.o_Game_Over);
        end
        chk("t3_over_cycles", no, 8);
        chk("t3_idle_active", int'(bus.o_Game_Active), 0);
        chk("t3_idle_freeze", int'(bus.o_Freeze), 0);
        chk("t3_idle_lives",  int'(bus.o_Lives), 0);
        repeat (5) tick();
        chk("t3_held_start_idle", int'(bus.o_Game_Active), 0);

        $display("step restart");
        bus.i_Start = 1'b0;
        tick();
        bus.i_Start = 1'b1;
        tick();
        chk("t5_active", int'(bus.o_Game_Active), 1);
        chk("t5_lives",  int'(bus.o_Lives), 7);
        chk("t5_level",  int'(bus.o_Level), 0);

        $display("step collision with level-up");
        bus.i_Has_Collided = 1'b1;
        bus.i_Level_Up     = 1'b1;
        tick();
        bus.i_Has_Collided = 1'b0;
        bus.i_Level_Up     = 1'b0;
        chk("t5_lives_hit",  int'(bus.o_Lives), 3);
        chk("t5_level_kept", int'(bus.o_Level), 0);
        chk("t5_freeze",     int'(bus.o_Freeze), 1);
        chk("t5_not_active", int'(bus.o_Game_Active), 0);
        repeat (4) tick();
        chk("t5_back_run", int'(bus.o_Game_Active), 1);

        for (int p = 0; p < 16; p++) begin
            $display("step level-up pulse %0d", p);
            bus.i_Level_Up = 1'b1;
            tick();
            bus.i_Level_Up = 1'b0;
            chk($sformatf("t4_level_%0d", p), int'(bus.o_Level), (p + 1 > 15) ? 15 : p + 1);
            nf = int'(bus.o_Freeze);
            for (int k = 0; k < 4; k++) begin
                tick();
                nf += int'(bus.o_Freeze);
            end
            chk($sformatf("t4_freeze_%0d", p), nf, 4);
            chk($sformatf("t4_respawn_%0d", p), int'(bus.o_Frog_Respawn), 1);
            tick();
        end
        chk("t4_level_sat", int'(bus.o_Level), 15);
        chk("t4_lives",     int'(bus.o_Lives), 3);

        $display("step reset during freeze");
        bus.i_Has_Collided = 1'b1;
        tick();
        bus.i_Has_Collided = 1'b0;
        tick();
        chk("t6_in_freeze", int'(bus.o_Freeze), 1);
        chk("t6_lives_pre", int'(bus.o_Lives), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_lives",   int'(bus.o_Lives), 7);
        chk("t6_level",   int'(bus.o_Level), 0);
        chk("t6_freeze",  int'(bus.o_Freeze), 0);
        chk("t6_active",  int'(bus.o_Game_Active), 0);
        chk("t6_respawn", int'(bus.o_Frog_Respawn), 0);
        chk("t6_over",    int'(bus.o_Game_Over), 0);
        bus.i_Start = 1'b0;
        tick();
        chk("t6_respawn_clk", int'(bus.o_Frog_Respawn), 0);
        rst_n = 1'b1;
        tick();
        chk("t6_idle_active", int'(bus.o_Game_Active), 0);

`ifdef GAME_PAUSE_EN
        $display("step pause");
        bus.i_Start = 1'b1;
        tick();
        chk("p_active", int'(bus.o_Game_Active), 1);
        tick();
        bus.i_Pause = 1'b1;
        tick();
        chk("p_freeze",     int'(bus.o_Freeze), 1);
        chk("p_not_active", int'(bus.o_Game_Active), 0);
        bus.i_Pause        = 1'b0;
        bus.i_Has_Collided = 1'b1;
        tick();
        chk("p_coll_ignored", int'(bus.o_Lives), 7);
        tick();
        bus.i_Pause = 1'b1;
        tick();
        chk("p_resume",     int'(bus.o_Game_Active), 1);
        chk("p_no_respawn", int'(bus.o_Frog_Respawn), 0);
        chk("p_lives",      int'(bus.o_Lives), 7);
        bus.i_Pause        = 1'b0;
        bus.i_Has_Collided = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
